reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular reorder buffer (ROB) of the out-of-order core.
- Allocates a tag per issued instruction and drives the register file's rename port (update_dep) at issue.
- Collects write-back results and retires in program order, driving the register file's value port (update_val).
- Detects branch mispredicts at commit and broadcasts rob_clear plus a redirect PC.

Parameters:
- ROB_SIZE_BIT, 3: tag width; depth ROB_SIZE = 2**ROB_SIZE_BIT (8).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low freezes all state
- issue_valid  input  1  decoder offers an instruction
- issue_has_rd  input  1  instruction writes rd
- issue_rd  input  5  destination register
- issue_is_branch  input  1  conditional branch / jalr
- issue_pred_taken  input  1  predicted direction
- issue_ready  output  1  ROB accepts issue this cycle
- issue_tag  output  ROB_SIZE_BIT  tag assigned (tail)
- wb_valid  input  1  CDB result valid
- wb_tag  input  ROB_SIZE_BIT  producing entry
- wb_val  input  32  result value
- wb_br_taken  input  1  resolved direction
- wb_br_target  input  32  correct next PC
- qry_tag1, qry_tag2  input  ROB_SIZE_BIT  operand producers to probe
- qry_ready1, qry_ready2  output  1  probed entry has its value
- qry_val1, qry_val2  output  32  probed value
- rf_dep_valid  output  1  to RF is_update_dep_in
- rf_dep_id  output  5  to RF update_dep_id
- rf_dep  output  ROB_SIZE_BIT  to RF update_dep
- rf_val_valid  output  1  to RF is_update_val_in
- rf_val_id  output  5  to RF update_val_id
- rf_val_dep  output  ROB_SIZE_BIT  to RF update_val_dep (committing tag)
- rf_val  output  32  to RF update_val
- rob_clear  output  1  flush pulse to RF and reservation stations
- redirect_pc  output  32  fetch target, valid with rob_clear

Behaviour:
- State: head, tail, count, clear_pend; per entry: busy, ready, has_rd, rd, is_branch, pred, taken, value, target.
- Reset (rst_n_in low, async): head = tail = count = 0, all busy = 0, clear_pend = 0.
  - All outputs 0 except issue_ready = 1 once rdy_in is high.
- rdy_in low: no state change; issue_ready, rf_dep_valid, rf_val_valid forced 0.
- issue_ready = rdy_in && count != ROB_SIZE && !clear_pend.
  - Computed from registered count; a same-cycle commit does not free a slot for issue.
- Issue accept = issue_valid && issue_ready.
  - At the edge: entry[tail] written busy = 1, ready = 0; tail += 1 (wraps mod ROB_SIZE).
  - issue_tag = tail (combinational).
  - rf_dep_valid = accept && issue_has_rd; rf_dep_id = issue_rd; rf_dep = tail.
  - rd = 0 is still allocated; the RF ignores it.
- Write-back: if entry[wb_tag].busy, set ready = 1 and store val, taken, target. Writes to non-busy entries are ignored.
- Commit: combinational from the head entry when count != 0 && entry[head].ready && !clear_pend.
  - rf_val_valid = commit && has_rd; rf_val_id = rd; rf_val_dep = head; rf_val = value.
  - At the edge: busy = 0, head += 1, count -= 1.
  - Write-back to the head lands at edge N; commit is visible in cycle N+1 (no same-cycle wb-to-commit bypass).
- Simultaneous issue and commit: count unchanged, both pointers advance.
- Mispredict: commit of is_branch with taken != pred at edge N.
  - The branch's rd write still occurs that cycle.
  - At edge N: all entries flushed (busy = 0, head = tail = count = 0), any same-cycle issue discarded, clear_pend = 1, redirect_pc latched = target.
  - Cycle N+1: rob_clear = 1, issue_ready = 0, no commit. clear_pend self-clears at edge N+1.
  - rob_clear is exactly one cycle wide.
- Operand query: qry_readyK = (entry[qry_tagK].busy && ready) || (wb_valid && wb_tag == qry_tagK); qry_valK selects the bypassed wb_val first.

Decomposition:
- Config.v holds ROB_SIZE_BIT and ROB_SIZE, shared with the RF and reservation stations.
- No sub-module; the entry arrays and pointer logic live in one module (about 250 lines).

Test Plan:
- Reset, then issue rd = 5, 6, 7 → issue_tag 0, 1, 2; rf_dep_valid each cycle with rf_dep 0, 1, 2; count = 3.
- wb tag 1 val 0x11 before tag 0 → no commit; after wb tag 0 val 0x22 → next cycle rf_val_valid, id 5, dep 0, val 0x22; following cycle id 6, val 0x11.
- Issue 8 entries without wb → issue_ready = 0 on the 9th; wb + commit of head, then issue_ready returns to 1 the cycle after the pop; tail wraps to 0.
- Branch tag 0 pred = 0, wb taken = 1 target 0x100, two younger entries issued → commit cycle, then rob_clear = 1 for one cycle with redirect_pc = 0x100; count = 0; younger wb ignored.
- qry_tag1 = 2 while wb_valid wb_tag = 2 val 0x33 → qry_ready1 = 1, qry_val1 = 0x33 the same cycle.
- rst_n_in low mid-sequence with 4 entries busy → immediately rf_*_valid = 0, rob_clear = 0; after release, issue_tag = 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer configuration and the per-entry record layout.
// The tag width default is shared with the register file and reservation stations.
package reorder_buffer_pkg;

    localparam int unsigned RobSizeBit = 3;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        has_rd;
        logic [4:0]  rd;
        logic        is_branch;
        logic        pred;
        logic        taken;
        logic [31:0] value;
        logic [31:0] target;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, collects write-backs and retires in order.
// A mispredicted branch at commit flushes every entry and pulses rob_clear for one cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = RobSizeBit
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic                    issue_has_rd,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_is_branch,
    input  logic                    issue_pred_taken,
    output logic                    issue_ready,
    output logic [ROB_SIZE_BIT-1:0] issue_tag,
    input  logic                    wb_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb_tag,
    input  logic [31:0]             wb_val,
    input  logic                    wb_br_taken,
    input  logic [31:0]             wb_br_target,
    input  logic [ROB_SIZE_BIT-1:0] qry_tag1,
    input  logic [ROB_SIZE_BIT-1:0] qry_tag2,
    output logic                    qry_ready1,
    output logic                    qry_ready2,
    output logic [31:0]             qry_val1,
    output logic [31:0]             qry_val2,
    output logic                    rf_dep_valid,
    output logic [4:0]              rf_dep_id,
    output logic [ROB_SIZE_BIT-1:0] rf_dep,
    output logic                    rf_val_valid,
    output logic [4:0]              rf_val_id,
    output logic [ROB_SIZE_BIT-1:0] rf_val_dep,
    output logic [31:0]             rf_val,
    output logic                    rob_clear,
    output logic [31:0]             redirect_pc
);

    localparam int unsigned ROB_SIZE = 2 ** ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0]   COUNT_FULL = (ROB_SIZE_BIT + 1)'(ROB_SIZE);
    localparam logic [ROB_SIZE_BIT:0]   COUNT_ONE  = (ROB_SIZE_BIT + 1)'(1);
    localparam logic [ROB_SIZE_BIT-1:0] PTR_ONE    = ROB_SIZE_BIT'(1);

    rob_entry_t              entries_q [ROB_SIZE];
    rob_entry_t              entries_d [ROB_SIZE];
    logic [ROB_SIZE_BIT-1:0] head_q, head_d;
    logic [ROB_SIZE_BIT-1:0] tail_q, tail_d;
    logic [ROB_SIZE_BIT:0]   count_q, count_d;
    logic                    clear_pend_q, clear_pend_d;
    logic [31:0]             redirect_pc_q, redirect_pc_d;

    logic       issue_accept;
    logic       commit;
    logic       mispredict;
    rob_entry_t head_entry;

    assign head_entry   = entries_q[head_q];
    // Readiness uses the registered count, so a same-cycle commit never frees a slot.
    assign issue_ready  = rdy_in && (count_q != COUNT_FULL) && !clear_pend_q;
    assign issue_accept = issue_valid && issue_ready;
    assign issue_tag    = tail_q;
    assign commit       = rdy_in && (count_q != '0) && head_entry.ready && !clear_pend_q;
    assign mispredict   = commit && head_entry.is_branch && (head_entry.taken != head_entry.pred);

    assign rf_dep_valid = issue_accept && issue_has_rd;
    assign rf_dep_id    = rf_dep_valid ? issue_rd : '0;
    assign rf_dep       = rf_dep_valid ? tail_q : '0;

    assign rf_val_valid = commit && head_entry.has_rd;
    assign rf_val_id    = rf_val_valid ? head_entry.rd : '0;
    assign rf_val_dep   = rf_val_valid ? head_q : '0;
    assign rf_val       = rf_val_valid ? head_entry.value : '0;

    assign rob_clear    = clear_pend_q;
    assign redirect_pc  = redirect_pc_q;

    // The CDB result is bypassed so a consumer probing its producer this cycle sees it.
    always_comb begin
        qry_ready1 = entries_q[qry_tag1].busy && entries_q[qry_tag1].ready;
        qry_val1   = entries_q[qry_tag1].value;
        qry_ready2 = entries_q[qry_tag2].busy && entries_q[qry_tag2].ready;
        qry_val2   = entries_q[qry_tag2].value;
        if (wb_valid && wb_tag == qry_tag1) begin
            qry_ready1 = 1'b1;
            qry_val1   = wb_val;
        end
        if (wb_valid && wb_tag == qry_tag2) begin
            qry_ready2 = 1'b1;
            qry_val2   = wb_val;
        end
    end

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        clear_pend_d  = clear_pend_q;
        redirect_pc_d = redirect_pc_q;

        if (rdy_in) begin
            clear_pend_d = 1'b0;

            if (wb_valid && entries_q[wb_tag].busy) begin
                entries_d[wb_tag].ready  = 1'b1;
                entries_d[wb_tag].value  = wb_val;
                entries_d[wb_tag].taken  = wb_br_taken;
                entries_d[wb_tag].target = wb_br_target;
            end

            if (issue_accept) begin
                entries_d[tail_q]           = '0;
                entries_d[tail_q].busy      = 1'b1;
                entries_d[tail_q].has_rd    = issue_has_rd;
                entries_d[tail_q].rd        = issue_rd;
                entries_d[tail_q].is_branch = issue_is_branch;
                entries_d[tail_q].pred      = issue_pred_taken;
                tail_d                      = tail_q + PTR_ONE;
            end

            if (commit) begin
                entries_d[head_q].busy = 1'b0;
                head_d                 = head_q + PTR_ONE;
            end

            unique case ({issue_accept, commit})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase

            // Flush wins over everything else this cycle, including a same-cycle issue.
            if (mispredict) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries_d[i].busy = 1'b0;
                end
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
                clear_pend_d  = 1'b1;
                redirect_pc_d = head_entry.target;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            clear_pend_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            clear_pend_q  <= clear_pend_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: issue-order scoreboard popped on every retirement,
// plus directed checks for ordering, full/wrap, freeze, mispredict flush, bypass and reset.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic        issue_pred_taken;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_val;
    logic        wb_br_taken;
    logic [31:0] wb_br_target;
    logic [2:0]  qry_tag1, qry_tag2;
    logic        qry_ready1, qry_ready2;
    logic [31:0] qry_val1, qry_val2;
    logic        rf_dep_valid;
    logic [4:0]  rf_dep_id;
    logic [2:0]  rf_dep;
    logic        rf_val_valid;
    logic [4:0]  rf_val_id;
    logic [2:0]  rf_val_dep;
    logic [31:0] rf_val;
    logic        rob_clear;
    logic [31:0] redirect_pc;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_val [8];
    int          n_checks = 0;
    int          n_pass   = 0;

    reorder_buffer #(.ROB_SIZE_BIT(3)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .rdy_in           (rdy_in),
        .issue_valid      (issue_valid),
        .issue_has_rd     (issue_has_rd),
        .issue_rd         (issue_rd),
        .issue_is_branch  (issue_is_branch),
        .issue_pred_taken (issue_pred_taken),
        .issue_ready      (issue_ready),
        .issue_tag        (issue_tag),
        .wb_valid         (wb_valid),
        .wb_tag           (wb_tag),
        .wb_val           (wb_val),
        .wb_br_taken      (wb_br_taken),
        .wb_br_target     (wb_br_target),
        .qry_tag1         (qry_tag1),
        .qry_tag2         (qry_tag2),
        .qry_ready1       (qry_ready1),
        .qry_ready2       (qry_ready2),
        .qry_val1         (qry_val1),
        .qry_val2         (qry_val2),
        .rf_dep_valid     (rf_dep_valid),
        .rf_dep_id        (rf_dep_id),
        .rf_dep           (rf_dep),
        .rf_val_valid     (rf_val_valid),
        .rf_val_id        (rf_val_id),
        .rf_val_dep       (rf_val_dep),
        .rf_val           (rf_val),
        .rob_clear        (rob_clear),
        .redirect_pc      (redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Every retirement must match the oldest outstanding issue.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_n_in && rf_val_valid) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_id", 32'(rf_val_id), 32'(e.rd));
                check("commit_dep", 32'(rf_val_dep), 32'(e.tag));
                check("commit_val", rf_val, exp_val[e.tag]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic pred,
                         input logic [2:0] tag);
        issue_valid      = 1'b1;
        issue_has_rd     = 1'b1;
        issue_rd         = rd;
        issue_is_branch  = br;
        issue_pred_taken = pred;
        #1;
        check("issue_ready", 32'(issue_ready), 32'd1);
        check("issue_tag", 32'(issue_tag), 32'(tag));
        check("rf_dep_valid", 32'(rf_dep_valid), 32'd1);
        check("rf_dep", 32'(rf_dep), 32'(tag));
        check("rf_dep_id", 32'(rf_dep_id), 32'(rd));
        exp_q.push_back('{rd: rd, tag: tag});
        tick();
        issue_valid      = 1'b0;
        issue_is_branch  = 1'b0;
        issue_pred_taken = 1'b0;
    endtask

    task automatic wb_send(input logic [2:0] tag, input logic [31:0] val, input logic taken,
                           input logic [31:0] target);
        wb_valid     = 1'b1;
        wb_tag       = tag;
        wb_val       = val;
        wb_br_taken  = taken;
        wb_br_target = target;
        exp_val[tag] = val;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = '0;
        issue_is_branch = 1'b0; issue_pred_taken = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_br_taken = 1'b0; wb_br_target = '0;
        qry_tag1 = '0; qry_tag2 = '0;
        for (int i = 0; i < 8; i++) exp_val[i] = '0;

        #12;
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_issue_tag", 32'(issue_tag), 32'd0);
        check("rst_rf_dep_valid", 32'(rf_dep_valid), 32'd0);
        check("rst_rf_val_valid", 32'(rf_val_valid), 32'd0);
        check("rst_rob_clear", 32'(rob_clear), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_qry_ready1", 32'(qry_ready1), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();

        // Three issues, then out-of-order write-back
        issue(5'd5, 1'b0, 1'b0, 3'd0);
        issue(5'd6, 1'b0, 1'b0, 3'd1);
        issue(5'd7, 1'b0, 1'b0, 3'd2);
        check("tail_after_3", 32'(issue_tag), 32'd3);
        wb_send(3'd1, 32'h11, 1'b0, 32'h0);
        check("no_commit_ooo", 32'(rf_val_valid), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd0; wb_val = 32'h22; exp_val[0] = 32'h22;
        #1;
        check("no_wb_bypass_commit", 32'(rf_val_valid), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("commit0_valid", 32'(rf_val_valid), 32'd1);
        tick();
        check("commit1_valid", 32'(rf_val_valid), 32'd1);
        tick();
        check("tag2_not_ready", 32'(rf_val_valid), 32'd0);

        // Operand query with same-cycle CDB bypass
        qry_tag1 = 3'd2; qry_tag2 = 3'd0;
        wb_valid = 1'b1; wb_tag = 3'd2; wb_val = 32'h33; exp_val[2] = 32'h33;
        #1;
        check("qry_bypass_ready", 32'(qry_ready1), 32'd1);
        check("qry_bypass_val", qry_val1, 32'h33);
        check("qry_retired_ready", 32'(qry_ready2), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("qry_stored_ready", 32'(qry_ready1), 32'd1);
        check("qry_stored_val", qry_val1, 32'h33);
        tick();
        wait_drain();

        // Fill all eight slots; tail wraps through 0
        for (int i = 0; i < 8; i++) issue(5'(i + 1), 1'b0, 1'b0, 3'(3 + i));
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd9;
        #1;
        check("full_issue_ready", 32'(issue_ready), 32'd0);
        check("full_rf_dep_valid", 32'(rf_dep_valid), 32'd0);
        issue_valid = 1'b0;

        // rdy_in low freezes state: this write-back must be lost
        rdy_in = 1'b0; wb_valid = 1'b1; wb_tag = 3'd3; wb_val = 32'hA3;
        #1;
        check("frozen_issue_ready", 32'(issue_ready), 32'd0);
        tick();
        rdy_in = 1'b1; wb_valid = 1'b0;
        check("frozen_wb_ignored", 32'(rf_val_valid), 32'd0);

        wb_send(3'd3, 32'hA3, 1'b0, 32'h0);
        check("full_commit_valid", 32'(rf_val_valid), 32'd1);
        check("full_during_commit", 32'(issue_ready), 32'd0);
        tick();
        check("ready_after_pop", 32'(issue_ready), 32'd1);
        check("tail_wrapped", 32'(issue_tag), 32'd3);
        for (int i = 1; i < 8; i++) wb_send(3'(3 + i), 32'h100 + i, 1'b0, 32'h0);
        wait_drain();

        // Asynchronous reset with four entries in flight
        for (int i = 0; i < 4; i++) issue(5'(20 + i), 1'b0, 1'b0, 3'(3 + i));
        wb_send(3'd3, 32'h55, 1'b0, 32'h0);
        check("pre_rst_commit", 32'(rf_val_valid), 32'd1);
        rst_n_in = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_val_valid", 32'(rf_val_valid), 32'd0);
        check("async_rst_dep_valid", 32'(rf_dep_valid), 32'd0);
        check("async_rst_rob_clear", 32'(rob_clear), 32'd0);
        check("async_rst_tag", 32'(issue_tag), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        tick();
        check("post_rst_tag", 32'(issue_tag), 32'd0);
        check("post_rst_ready", 32'(issue_ready), 32'd1);

        // Mispredicted branch at tag 0 with two younger entries
        issue(5'd10, 1'b1, 1'b0, 3'd0);
        issue(5'd11, 1'b0, 1'b0, 3'd1);
        issue(5'd12, 1'b0, 1'b0, 3'd2);
        wb_send(3'd0, 32'h44, 1'b1, 32'h100);
        check("br_commit_valid", 32'(rf_val_valid), 32'd1);
        check("br_no_clear_yet", 32'(rob_clear), 32'd0);
        issue_valid = 1'b1; issue_rd = 5'd13;
        tick();
        issue_valid = 1'b0;
        exp_q.delete();
        check("clear_pulse", 32'(rob_clear), 32'd1);
        check("redirect_pc", redirect_pc, 32'h100);
        check("clear_issue_ready", 32'(issue_ready), 32'd0);
        check("clear_no_commit", 32'(rf_val_valid), 32'd0);
        tick();
        check("clear_one_cycle", 32'(rob_clear), 32'd0);
        check("post_flush_ready", 32'(issue_ready), 32'd1);
        check("post_flush_tag", 32'(issue_tag), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd1; wb_val = 32'h77;
        tick();
        wb_valid = 1'b0; qry_tag1 = 3'd1;
        #1;
        check("flushed_wb_ignored", 32'(qry_ready1), 32'd0);
        check("flushed_no_commit", 32'(rf_val_valid), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
